// File: rtl/cl_pkg.sv
// Shared definitions for the Camera Link pixel unpacker.
// Contents:
//   cl_mode_e   - runtime pixel-width encodings as presented on pix_mode
//   cl_state_e  - frame/line FSM states of the top level
//   PIX_W       - width of one output pixel slot (widest pixel)
//   RES_W       - widest residual a half can carry between cycles (PIX_W-1)
//   log2()      - ceiling log2, for sizing counters
//   pix_width() - pixel width in bits for a mode
package cl_pkg;

  typedef enum logic [1:0] {
    CL_MODE_8   = 2'd0,
    CL_MODE_10  = 2'd1,
    CL_MODE_12  = 2'd2,
    CL_MODE_BAD = 2'd3
  } cl_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INTERLINE = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_BAD       = 2'd3
  } cl_state_e;

  localparam int PIX_W = 12;
  localparam int RES_W = PIX_W - 1;

  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // The illegal mode never reaches the datapath; it maps to 12 bits only so
  // the function is total.
  function automatic logic [3:0] pix_width(input cl_mode_e mode);
    case (mode)
      CL_MODE_8:  return 4'd8;
      CL_MODE_10: return 4'd10;
      default:    return 4'd12;
    endcase
  endfunction

endpackage

// File: rtl/cl_bit_repacker.sv
// Bit repacker for one half (top or bottom) of a Camera Link pixel clock.
// Appends the new bytes behind the residual bits left from earlier cycles,
// slices off as many whole pw-bit pixels as fit (oldest first, MSB-first
// bit order) and keeps the remainder for the next cycle.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   consume_i    - accept data_i this cycle and update the residual
//   flush_i      - discard the residual (line end / frame start)
//   pw_i         - pixel width in bits: 8, 10 or 12
//   data_i       - 8*BYTES_PER_HALF bits, byte 0 (oldest) at the MSBs
//   n_o          - number of complete pixels available this cycle
//   slots_o      - pixel slots, slot 0 at MSBs, right-justified, zero-filled
//   residue_o    - residual bits are pending
module cl_bit_repacker
  import cl_pkg::*;
#(
  parameter int BYTES_PER_HALF = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            consume_i,
  input  logic                            flush_i,
  input  logic [3:0]                      pw_i,
  input  logic [8*BYTES_PER_HALF-1:0]     data_i,
  output logic [2:0]                      n_o,
  output logic [PIX_W*BYTES_PER_HALF-1:0] slots_o,
  output logic                            residue_o
);

  localparam int DATA_W  = 8 * BYTES_PER_HALF;
  localparam int ACC_W   = DATA_W + RES_W;
  localparam int MAX_PIX = BYTES_PER_HALF;
  localparam int BITS_W  = log2(ACC_W + 1);

  logic [RES_W-1:0]  res_q, res_d;
  logic [BITS_W-1:0] bits_q, bits_d;
  logic [ACC_W-1:0]  acc_new;
  logic [ACC_W-1:0]  field;
  logic [BITS_W-1:0] bits_new;
  logic [PIX_W-1:0]  pix_mask;
  logic [2:0]        n;

  // NOTE: every signal written below gets a value before any branch, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    slots_o  = '0;
    field    = '0;
    // Residual is right-justified, so the new bytes simply follow it.
    acc_new  = {res_q, data_i};
    bits_new = bits_q + BITS_W'(DATA_W);
    pix_mask = ~({PIX_W{1'b1}} << pw_i);

    case (pw_i)
      4'd8:    n = 3'(bits_new / 8);
      4'd10:   n = 3'(bits_new / 10);
      default: n = 3'(bits_new / 12);
    endcase

    for (int i = 0; i < MAX_PIX; i++) begin
      if (i < int'(n)) begin
        field = acc_new >> (int'(bits_new) - (i + 1) * int'(pw_i));
        slots_o[PIX_W*(MAX_PIX-1-i) +: PIX_W] = field[PIX_W-1:0] & pix_mask;
      end
    end

    bits_d = BITS_W'(int'(bits_new) - int'(n) * int'(pw_i));
    res_d  = RES_W'(acc_new & ~({ACC_W{1'b1}} << bits_d));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      res_q  <= '0;
      bits_q <= '0;
    end else if (consume_i) begin
      res_q  <= res_d;
      bits_q <= bits_d;
    end
  end

  assign n_o       = n;
  assign residue_o = (bits_q != '0);

endmodule

// File: rtl/cl_pixel_unpacker.sv
// Camera Link pixel unpacker: repacks the top and bottom byte halves into
// 8/10/12-bit pixels and annotates each output word with its column span,
// row, frame count and start-of-frame / end-of-line markers.
// Ports:
//   cl_clk, reset_n     - pixel clock, synchronous active-low reset
//   cl_fval, cl_lval    - frame / line valid
//   cl_top, cl_btm      - byte halves, byte 0 at the MSBs
//   pix_mode            - 0 = 8-bit, 1 = 10-bit, 2 = 12-bit, 3 = illegal;
//                         sampled only on the fval rising edge
//   pix_valid/pix_count - word valid (one cycle after the bytes) and size
//   pix_top, pix_btm    - pixel slots, slot 0 at the MSBs
//   l_col, r_col        - column of slot 0 and l_col + pix_count
//   row, frame          - row of the word, frames completed
//   sof, eol            - first word of frame, last word of line
//   residue_err         - sticky: a line ended with leftover bits
//   mode_err            - sticky: a frame started with the illegal mode
// The end of a line is only visible when lval drops, one cycle after the
// last word was presented; eol therefore pulses in that following cycle,
// with the last word's data and columns still held on the outputs and
// pix_valid low, so no pixel is delivered twice.
module cl_pixel_unpacker
  import cl_pkg::*;
#(
  parameter int BYTES_PER_HALF = 5,
  parameter int N_COL_SIZE     = 12,
  parameter int N_ROW_SIZE     = 11,
  parameter int N_FRAME_SIZE   = 20
) (
  input  logic                            cl_clk,
  input  logic                            reset_n,
  input  logic                            cl_fval,
  input  logic                            cl_lval,
  input  logic [8*BYTES_PER_HALF-1:0]     cl_top,
  input  logic [8*BYTES_PER_HALF-1:0]     cl_btm,
  input  logic [1:0]                      pix_mode,
  output logic                            pix_valid,
  output logic [2:0]                      pix_count,
  output logic [PIX_W*BYTES_PER_HALF-1:0] pix_top,
  output logic [PIX_W*BYTES_PER_HALF-1:0] pix_btm,
  output logic [N_COL_SIZE-1:0]           l_col,
  output logic [N_COL_SIZE-1:0]           r_col,
  output logic [N_ROW_SIZE-1:0]           row,
  output logic [N_FRAME_SIZE-1:0]         frame,
  output logic                            sof,
  output logic                            eol,
  output logic                            residue_err,
  output logic                            mode_err
);

  cl_state_e               state_q, state_d;
  cl_mode_e                mode_q;
  logic                    fval_d_q, lval_d_q;
  logic                    sof_armed_q;
  logic [N_COL_SIZE-1:0]   col_q, col_base, col_next;
  logic [N_ROW_SIZE-1:0]   row_q;

  logic                    fval_rise, consume, line_end, frame_end;
  logic [3:0]              pw;
  logic [2:0]              n_top, n_btm;
  logic [PIX_W*BYTES_PER_HALF-1:0] slots_top, slots_btm;
  logic                    res_top, res_btm;

  assign fval_rise = cl_fval && !fval_d_q;
  assign consume   = cl_fval && cl_lval &&
                     ((state_q == ST_INTERLINE) || (state_q == ST_ACTIVE));
  // A frame dropping mid-line also closes that line.
  assign line_end  = (state_q == ST_ACTIVE) &&
                     ((lval_d_q && !cl_lval) || !cl_fval);
  // Only frames that were actually started are counted.
  assign frame_end = (state_q != ST_IDLE) && !cl_fval;
  assign pw        = pix_width(mode_q);
  assign col_base  = (state_q == ST_INTERLINE) ? '0 : col_q;
  assign col_next  = col_base + N_COL_SIZE'(n_top);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (fval_rise)
                      state_d = (pix_mode == CL_MODE_BAD) ? ST_BAD : ST_INTERLINE;
      ST_INTERLINE: if (cl_lval)  state_d = ST_ACTIVE;
      ST_ACTIVE:    if (!cl_lval) state_d = ST_INTERLINE;
      ST_BAD:       state_d = ST_BAD;
      default:      state_d = ST_IDLE;
    endcase
    if (!cl_fval) state_d = ST_IDLE;
  end

  always_ff @(posedge cl_clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= CL_MODE_12;
      fval_d_q    <= 1'b0;
      lval_d_q    <= 1'b0;
      sof_armed_q <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      pix_valid   <= 1'b0;
      pix_count   <= '0;
      pix_top     <= '0;
      pix_btm     <= '0;
      l_col       <= '0;
      r_col       <= '0;
      row         <= '0;
      frame       <= '0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      residue_err <= 1'b0;
      mode_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fval_d_q  <= cl_fval;
      lval_d_q  <= cl_lval;
      pix_valid <= consume;
      sof       <= consume && sof_armed_q;
      eol       <= line_end;

      if (fval_rise) begin
        mode_q      <= cl_mode_e'(pix_mode);
        row_q       <= '0;
        sof_armed_q <= 1'b1;
        if (pix_mode == CL_MODE_BAD) mode_err <= 1'b1;
      end else begin
        if (consume)  sof_armed_q <= 1'b0;
        if (line_end) row_q       <= row_q + 1'b1;
      end

      if (consume) begin
        col_q     <= col_next;
        pix_count <= n_top;
        pix_top   <= slots_top;
        pix_btm   <= slots_btm;
        l_col     <= col_base;
        r_col     <= col_next;
        row       <= row_q;
      end

      if (line_end && (res_top || res_btm)) residue_err <= 1'b1;
      if (frame_end) frame <= frame + 1'b1;
    end
  end

  cl_bit_repacker #(.BYTES_PER_HALF(BYTES_PER_HALF)) u_rep_top (
    .clk       (cl_clk),
    .rst_n     (reset_n),
    .consume_i (consume),
    .flush_i   (line_end || fval_rise),
    .pw_i      (pw),
    .data_i    (cl_top),
    .n_o       (n_top),
    .slots_o   (slots_top),
    .residue_o (res_top)
  );

  cl_bit_repacker #(.BYTES_PER_HALF(BYTES_PER_HALF)) u_rep_btm (
    .clk       (cl_clk),
    .rst_n     (reset_n),
    .consume_i (consume),
    .flush_i   (line_end || fval_rise),
    .pw_i      (pw),
    .data_i    (cl_btm),
    .n_o       (n_btm),
    .slots_o   (slots_btm),
    .residue_o (res_btm)
  );

  // Both halves see the same bit counts, so they always agree on the count.
  a_halves_agree: assert property (@(posedge cl_clk) disable iff (!reset_n)
                                   consume |-> (n_top == n_btm));

endmodule

// File: tb/tb_cl_pixel_unpacker.sv
module tb_cl_pixel_unpacker;

  logic        cl_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cl_fval = 1'b0;
  logic        cl_lval = 1'b0;
  logic [39:0] cl_top = '0;
  logic [39:0] cl_btm = '0;
  logic [1:0]  pix_mode = 2'd2;

  logic        pix_valid;
  logic [2:0]  pix_count;
  logic [59:0] pix_top, pix_btm;
  logic [11:0] l_col, r_col;
  logic [10:0] row;
  logic [19:0] frame;
  logic        sof, eol, residue_err, mode_err;

  cl_pixel_unpacker dut (
    .cl_clk      (cl_clk),
    .reset_n     (reset_n),
    .cl_fval     (cl_fval),
    .cl_lval     (cl_lval),
    .cl_top      (cl_top),
    .cl_btm      (cl_btm),
    .pix_mode    (pix_mode),
    .pix_valid   (pix_valid),
    .pix_count   (pix_count),
    .pix_top     (pix_top),
    .pix_btm     (pix_btm),
    .l_col       (l_col),
    .r_col       (r_col),
    .row         (row),
    .frame       (frame),
    .sof         (sof),
    .eol         (eol),
    .residue_err (residue_err),
    .mode_err    (mode_err)
  );

  always #5 cl_clk = ~cl_clk;

  typedef struct {
    logic [2:0]  cnt;
    logic [59:0] top;
    logic [59:0] btm;
    logic [11:0] lc;
    logic [11:0] rc;
    logic [10:0] row;
    logic        sof;
  } word_t;

  word_t       exp_q[$];
  logic [23:0] eol_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [59:0] mk(input logic [11:0] a, b, c, d, e);
    return {a, b, c, d, e};
  endfunction

  task automatic push(input logic [2:0] cnt, input logic [59:0] t, input logic [59:0] b,
                      input logic [11:0] lc, input logic [11:0] rc,
                      input logic [10:0] r, input logic s);
    word_t w;
    w.cnt = cnt; w.top = t; w.btm = b; w.lc = lc; w.rc = rc; w.row = r; w.sof = s;
    exp_q.push_back(w);
  endtask

  task automatic push_eol(input logic [11:0] lc, input logic [11:0] rc);
    eol_q.push_back({lc, rc});
  endtask

  task automatic tick();
    @(posedge cl_clk);
    #1;
  endtask

  task automatic start_frame(input logic [1:0] m);
    pix_mode = m;
    cl_fval  = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_frame();
    cl_fval = 1'b0;
    repeat (3) tick();
  endtask

  task automatic run_line(input int cycles, input logic [39:0] t, input logic [39:0] b);
    for (int c = 0; c < cycles; c++) begin
      cl_lval = 1'b1;
      cl_top  = t;
      cl_btm  = b;
      tick();
    end
    cl_lval = 1'b0;
    cl_top  = '0;
    cl_btm  = '0;
    repeat (3) tick();
  endtask

  // Monitor: compares every presented word and every eol pulse against the
  // expectations queued by the stimulus.
  initial begin
    word_t       w;
    logic [23:0] e;
    int          idx;
    idx = 0;
    forever begin
      @(negedge cl_clk);
      if (pix_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_word%0d", idx), 64'd1, 64'd0);
        end else begin
          w = exp_q.pop_front();
          check($sformatf("word%0d_count", idx), 64'(pix_count), 64'(w.cnt));
          check($sformatf("word%0d_top", idx), 64'(pix_top), 64'(w.top));
          check($sformatf("word%0d_btm", idx), 64'(pix_btm), 64'(w.btm));
          check($sformatf("word%0d_cols", idx), 64'({l_col, r_col}), 64'({w.lc, w.rc}));
          check($sformatf("word%0d_row", idx), 64'(row), 64'(w.row));
          check($sformatf("word%0d_sof", idx), 64'(sof), 64'(w.sof));
        end
        idx++;
      end
      if (eol === 1'b1) begin
        if (eol_q.size() == 0) begin
          check("unexpected_eol", 64'd1, 64'd0);
        end else begin
          e = eol_q.pop_front();
          check("eol_cols", 64'({l_col, r_col}), 64'(e));
        end
      end
    end
  end

  localparam logic [39:0] T12 = 40'hABCDEF1234;
  localparam logic [39:0] B12 = 40'h0011223344;
  localparam logic [39:0] T10 = 40'hFFC00FFC00;
  localparam logic [39:0] B10 = 40'h003FF003FF;
  localparam logic [39:0] T8  = 40'h0102030405;
  localparam logic [39:0] B8  = 40'h1020304050;

  initial begin
    logic [59:0] t12_1, t12_2, t12_3, b12_1, b12_2, b12_3;
    logic [59:0] t10, b10, t8, b8;
    t12_1 = mk(12'hABC, 12'hDEF, 12'h123, 12'h000, 12'h000);
    t12_2 = mk(12'h4AB, 12'hCDE, 12'hF12, 12'h000, 12'h000);
    t12_3 = mk(12'h34A, 12'hBCD, 12'hEF1, 12'h234, 12'h000);
    b12_1 = mk(12'h001, 12'h122, 12'h334, 12'h000, 12'h000);
    b12_2 = mk(12'h400, 12'h112, 12'h233, 12'h000, 12'h000);
    b12_3 = mk(12'h440, 12'h011, 12'h223, 12'h344, 12'h000);
    t10   = mk(12'h3FF, 12'h000, 12'h3FF, 12'h000, 12'h000);
    b10   = mk(12'h000, 12'h3FF, 12'h000, 12'h3FF, 12'h000);
    t8    = mk(12'h001, 12'h002, 12'h003, 12'h004, 12'h005);
    b8    = mk(12'h010, 12'h020, 12'h030, 12'h040, 12'h050);

    // Reset state
    repeat (3) tick();
    check("rst_pix_valid", 64'(pix_valid), 64'd0);
    check("rst_ctrl", 64'({pix_count, l_col, r_col, row, frame, sof, eol, residue_err, mode_err}), 64'd0);
    check("rst_pix", 64'(pix_top | pix_btm), 64'd0);
    reset_n = 1'b1;
    tick();

    // 12-bit frame: 3-cycle line, 2-cycle line (residue), then mode switch
    start_frame(2'd2);
    push(3'd3, t12_1, b12_1, 12'd0, 12'd3,  11'd0, 1'b1);
    push(3'd3, t12_2, b12_2, 12'd3, 12'd6,  11'd0, 1'b0);
    push(3'd4, t12_3, b12_3, 12'd6, 12'd10, 11'd0, 1'b0);
    push_eol(12'd6, 12'd10);
    run_line(3, T12, B12);
    check("residue_clean_line", 64'(residue_err), 64'd0);

    push(3'd3, t12_1, b12_1, 12'd0, 12'd3, 11'd1, 1'b0);
    push(3'd3, t12_2, b12_2, 12'd3, 12'd6, 11'd1, 1'b0);
    push_eol(12'd3, 12'd6);
    run_line(2, T12, B12);
    check("residue_after_short_line", 64'(residue_err), 64'd1);

    pix_mode = 2'd0;  // must not take effect until the next frame
    push(3'd3, t12_1, b12_1, 12'd0, 12'd3, 11'd2, 1'b0);
    push_eol(12'd0, 12'd3);
    run_line(1, T12, B12);
    end_frame();
    check("frame_after_f1", 64'(frame), 64'd1);

    // 8-bit frame
    start_frame(2'd0);
    push(3'd5, t8, b8, 12'd0, 12'd5, 11'd0, 1'b1);
    push_eol(12'd0, 12'd5);
    run_line(1, T8, B8);
    end_frame();
    check("frame_after_f2", 64'(frame), 64'd2);
    check("residue_sticky", 64'(residue_err), 64'd1);

    // 10-bit frame
    start_frame(2'd1);
    push(3'd4, t10, b10, 12'd0, 12'd4, 11'd0, 1'b1);
    push(3'd4, t10, b10, 12'd4, 12'd8, 11'd0, 1'b0);
    push_eol(12'd4, 12'd8);
    run_line(2, T10, B10);
    end_frame();
    check("frame_after_f3", 64'(frame), 64'd3);

    // Illegal-mode frame: no words expected at all
    check("mode_err_before", 64'(mode_err), 64'd0);
    start_frame(2'd3);
    run_line(2, T12, B12);
    run_line(1, T8, B8);
    end_frame();
    check("mode_err_after", 64'(mode_err), 64'd1);
    check("frame_after_bad", 64'(frame), 64'd4);

    // Reset in the middle of a line
    start_frame(2'd2);
    push(3'd3, t12_1, b12_1, 12'd0, 12'd3, 11'd0, 1'b1);
    cl_lval = 1'b1;
    cl_top  = T12;
    cl_btm  = B12;
    tick();
    reset_n = 1'b0;
    cl_fval = 1'b0;
    cl_lval = 1'b0;
    tick();
    tick();
    check("midrst_pix_valid", 64'(pix_valid), 64'd0);
    check("midrst_ctrl", 64'({pix_count, l_col, r_col, row, frame, sof, eol, residue_err, mode_err}), 64'd0);
    check("midrst_pix", 64'(pix_top | pix_btm), 64'd0);
    reset_n = 1'b1;
    tick();

    // Three frames of two lines each
    for (int f = 0; f < 3; f++) begin
      start_frame(2'd0);
      for (int l = 0; l < 2; l++) begin
        push(3'd5, t8, b8, 12'd0, 12'd5, 11'(l), (l == 0));
        push_eol(12'd0, 12'd5);
        run_line(1, T8, B8);
      end
      end_frame();
    end
    check("frame_after_rst", 64'(frame), 64'd3);
    check("errs_after_rst", 64'({residue_err, mode_err}), 64'd0);

    repeat (2) tick();
    check("words_drained", 64'(exp_q.size()), 64'd0);
    check("eols_drained", 64'(eol_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cl_pixel_unpacker.md
Name: cl_pixel_unpacker

Overview:
- Parametrised successor to the fixed 12-bit Camera Link unpack logic.
- Takes two halves (top/btm) of BYTES_PER_HALF Camera Link bytes per pixel clock and repacks them into 8-, 10- or 12-bit pixels. The pixel width is a runtime mode, latched at frame start.
- Emits a variable pixel count per cycle with column span (l_col/r_col), row, frame markers and sticky error flags.
- Feeds PatchRowMatcher instances and the capture logic.

Parameters:
- BYTES_PER_HALF, 5: Camera Link bytes per half per clock. Top half is the low-index bytes (port A first); bottom half is the high-index bytes.
- N_COL_SIZE, 12: column counter width.
- N_ROW_SIZE, 11: row counter width.
- N_FRAME_SIZE, 20: frame counter width.

Ports:
- cl_clk  in  1  Camera Link pixel clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- cl_fval  in  1  frame valid.
- cl_lval  in  1  line valid.
- cl_top  in  8*BYTES_PER_HALF  top-half bytes; byte 0 is at the MSBs.
- cl_btm  in  8*BYTES_PER_HALF  bottom-half bytes; byte 0 is at the MSBs.
- pix_mode  in  2  0 = 8-bit, 1 = 10-bit, 2 = 12-bit, 3 = illegal.
- pix_valid  out  1  pixel words valid this cycle.
- pix_count  out  3  number of valid pixels, 0..MAX_PIX.
- pix_top  out  12*MAX_PIX  top pixels; slot 0 at the MSBs; right-justified, zero-extended.
- pix_btm  out  12*MAX_PIX  bottom pixels; same format as pix_top.
- l_col  out  N_COL_SIZE  column of slot 0.
- r_col  out  N_COL_SIZE  l_col + pix_count.
- row  out  N_ROW_SIZE  row of the current line.
- frame  out  N_FRAME_SIZE  frames completed.
- sof  out  1  first pixel word of a frame.
- eol  out  1  last pixel word of a line.
- residue_err  out  1  sticky; leftover bits at line end.
- mode_err  out  1  sticky; frame started with pix_mode = 3.

Behaviour:
- Derived: MAX_PIX = BYTES_PER_HALF (8-bit worst case); per-half accumulator width ACC_W = 8*BYTES_PER_HALF + 11.
- Reset (reset_n = 0 at a cl_clk edge) clears:
  - every output to 0;
  - accumulators, bit counts, col, row, frame;
  - active mode, which becomes 12-bit;
  - state, which becomes IDLE.
- Reset mid-line discards all partial data.
- Registered inputs: fval_d, lval_d.
- cl_fval rising edge (cl_fval = 1, fval_d = 0):
  - latch pix_mode into the active mode;
  - row <= 0;
  - arm sof;
  - if pix_mode = 3, set mode_err and enter state BAD.
  - pix_mode changes at any other time have no effect.
- States:
  - IDLE: waits for the fval rising edge, then goes to INTERLINE, or to BAD if pix_mode = 3.
  - INTERLINE: on cl_lval = 1 goes to ACTIVE and that cycle's bytes are consumed.
  - ACTIVE: stays while cl_lval = 1; on cl_lval = 0 goes back to INTERLINE.
  - fval low from any state returns to IDLE and frame increments, wrapping at 2^N_FRAME_SIZE.
  - BAD: no pixels are output until fval falls.
- Unpack, per half, on each ACTIVE cycle:
  - bits_new = bits + 8*BYTES_PER_HALF;
  - n = floor(bits_new / pw), where pw is 8, 10 or 12;
  - output the n oldest pw-bit fields, MSB-first bit order;
  - keep bits_new - n*pw residual bits.
  - Top and bottom halves always produce the same n, so pix_count = n.
- Output latency is 1 cycle from the input bytes: pix_valid = 1 and outputs are valid the cycle after the consuming edge.
- Column tracking: l_col <= running col and r_col <= col + n; col resets to 0 at each line start. Columns wrap modulo 2^N_COL_SIZE with no error.
- Line and frame markers:
  - eol is asserted on the output word of the last lval-high cycle; it is detected on the lval falling edge, so that word is held one extra cycle.
  - row increments after each line end.
  - sof is asserted with the first pix_valid after the fval rising edge.
- Line end with residual bits != 0: set residue_err and discard the residual bits.
- lval high while fval is low: ignored, no output.

Decomposition:
- Shared package (cl_pkg.vh): mode encodings CL_MODE_8/10/12/BAD; state encodings; helper functions log2() (existing, function.v) and pix_width(mode).
- Sub-module cl_bit_repacker: one per half, instantiated twice. It holds the accumulator, bit count and extraction mux, and outputs n plus the pixel slots.
- The top level owns the FSM, counters and markers.

Test Plan:
- 12-bit mode, one line of 3 cycles. Top bytes cycle 1 = AB CD EF 12 34. Required response:
  - pix_count 3, 3, 4;
  - first word slot 0 = 0xABC, slot 1 = 0xDEF, slot 2 = 0x123;
  - (l_col, r_col) = (0,3), (3,6), (6,10);
  - eol on the third word; residue_err = 0.
- 10-bit mode, bytes FF C0 0F FC 00 -> slots 0x3FF, 0x000, 0x3FF, 0x000; count 4 every cycle.
- 8-bit mode, bytes 01 02 03 04 05 -> count 5, slots 0x001..0x005, r_col 5.
- 12-bit mode, line of 2 cycles -> counts 3, 3; residue_err = 1 after the line; the next line starts at l_col = 0 with an empty accumulator.
- pix_mode switched 2 -> 0 mid-frame -> output stays 12-bit until the next fval rise, then becomes 8-bit. pix_mode = 3 at a frame start -> mode_err = 1 and no pix_valid for that frame.
- Reset mid-line followed by 3 frames of 2 lines -> all outputs 0 while in reset; afterwards frame = 3, row returns to 0 at each sof, and sof is asserted exactly once per frame.
